// File: rtl/ptw_walker.sv
// ptw_walker: two-level page-table walker with a per-level memory response timeout.
// Define PTW_SUPERPAGE_EN to treat a valid level-1 PTE with L set as a superpage leaf.
module ptw_walker #(
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ptw_req_valid_i,
   output logic        ptw_req_ready_o,
   input  logic [31:0] ptw_vaddr_i,
   input  logic [19:0] ptbr_i,
   output logic        ptw_resp_valid_o,
   input  logic        ptw_resp_ready_i,
   output logic [31:0] ptw_pte_o,
   output logic        mem_req_valid_o,
   input  logic        mem_req_ready_i,
   output logic [31:0] mem_addr_o,
   input  logic        mem_resp_valid_i,
   output logic        mem_resp_ready_o,
   input  logic [31:0] mem_rdata_i
);
   typedef enum logic [2:0] {IDLE, L1_REQ, L1_WAIT, L0_REQ, L0_WAIT, RESP} state_e;
   state_e      state_q, state_d;
   logic [19:0] vpn_q, vpn_d, ptbr_q, ptbr_d, pte1_q, pte1_d;
   logic [31:0] res_q, res_d;
   logic [15:0] cnt_q, cnt_d;
   logic        waiting, expired, unused_ok;
   assign unused_ok        = ^ptw_vaddr_i[11:0];
   assign waiting          = state_q == L1_WAIT || state_q == L0_WAIT;
   assign expired          = cnt_q == 16'(TIMEOUT_CYCLES - 1);
   assign ptw_req_ready_o  = rst_n && state_q == IDLE;
   assign ptw_resp_valid_o = state_q == RESP;
   assign ptw_pte_o        = ptw_resp_valid_o ? res_q : 32'h0;
   assign mem_req_valid_o  = state_q == L1_REQ || state_q == L0_REQ;
   assign mem_resp_ready_o = waiting;
   assign mem_addr_o       = state_q == L1_REQ ? {ptbr_q, vpn_q[19:10], 2'b00} :
                             state_q == L0_REQ ? {pte1_q, vpn_q[9:0], 2'b00} : 32'h0;
   always_comb begin
      state_d = state_q;
      vpn_d   = vpn_q;
      ptbr_d  = ptbr_q;
      pte1_d  = pte1_q;
      res_d   = res_q;
      // Counter runs only while waiting, so it is zero on entry to each WAIT state
      cnt_d   = waiting ? cnt_q + 16'd1 : 16'd0;
      case (state_q)
         IDLE: if (ptw_req_valid_i) begin
            vpn_d   = ptw_vaddr_i[31:12];
            ptbr_d  = ptbr_i;
            state_d = L1_REQ;
         end
         L1_REQ: if (mem_req_ready_i) state_d = L1_WAIT;
         L1_WAIT: if (mem_resp_valid_i) begin
            pte1_d  = mem_rdata_i[31:12];
            res_d   = 32'h0;
            state_d = mem_rdata_i[0] ? L0_REQ : RESP;
`ifdef PTW_SUPERPAGE_EN
            if (mem_rdata_i[0] && mem_rdata_i[2]) begin
               res_d   = {mem_rdata_i[31:22], vpn_q[9:0], mem_rdata_i[11:0]};
               state_d = RESP;
            end
`endif
         end else if (expired) begin
            res_d   = 32'h0;
            state_d = RESP;
         end
         L0_REQ: if (mem_req_ready_i) state_d = L0_WAIT;
         L0_WAIT: if (mem_resp_valid_i || expired) begin
            res_d   = mem_resp_valid_i && mem_rdata_i[0] ? mem_rdata_i : 32'h0;
            state_d = RESP;
         end
         RESP: if (ptw_resp_ready_i) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         vpn_q   <= '0;
         ptbr_q  <= '0;
         pte1_q  <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         vpn_q   <= vpn_d;
         ptbr_q  <= ptbr_d;
         pte1_q  <= pte1_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
      end
   end
endmodule

// File: tb/tb_ptw_walker.sv
// tb_ptw_walker: directed walks checked against a page-table model built from the translation rules,
// with a per-cycle output monitor and a behavioural memory responder.
`timescale 1ns/1ps
module tb_ptw_walker;
   localparam int T = 16;
   logic        clk = 1'b0, rst_n = 1'b0;
   logic        ptw_req_valid_i = 1'b0, ptw_resp_ready_i = 1'b0;
   logic [31:0] ptw_vaddr_i = '0;
   logic [19:0] ptbr_i = '0;
   logic        ptw_req_ready_o, ptw_resp_valid_o, mem_req_valid_o, mem_resp_ready_o;
   logic [31:0] ptw_pte_o, mem_addr_o;
   logic        mem_req_ready_i, mem_resp_valid_i;
   logic [31:0] mem_rdata_i;

   ptw_walker #(.TIMEOUT_CYCLES(T)) dut (
      .clk(clk), .rst_n(rst_n),
      .ptw_req_valid_i(ptw_req_valid_i), .ptw_req_ready_o(ptw_req_ready_o),
      .ptw_vaddr_i(ptw_vaddr_i), .ptbr_i(ptbr_i),
      .ptw_resp_valid_o(ptw_resp_valid_o), .ptw_resp_ready_i(ptw_resp_ready_i),
      .ptw_pte_o(ptw_pte_o),
      .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
      .mem_addr_o(mem_addr_o),
      .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o),
      .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk = ~clk;

   int tests = 0, fails = 0;
   logic [31:0] mem [logic [31:0]];
   bit          busy = 1'b0, no_resp = 1'b0, pend = 1'b0;
   int          stall_left = 0, resp_dly = 0, dly_left = 0, n_grants = 0, exp_n = 0, lat = 0;
   logic [31:0] pend_addr = '0, exp_res = '0, got_pte = '0;
   logic [31:0] got_addr [2];
   logic [31:0] exp_addr [2];

   function automatic logic [31:0] rd(input logic [31:0] a);
      return mem.exists(a) ? mem[a] : 32'h0;
   endfunction

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   // Expected addresses and result from the translation rules; a level whose response
   // latency reaches the timeout counts as lost.
   task automatic model(input logic [19:0] pt, input logic [31:0] va);
      logic [31:0] p1, p0;
      bit lost;
      lost        = no_resp || resp_dly >= T;
      exp_addr[0] = 32'(pt) * 32'd4096 + 32'(va[31:22]) * 32'd4;
      exp_addr[1] = 32'h0;
      exp_n       = 1;
      exp_res     = 32'h0;
      p1          = rd(exp_addr[0]);
      if (lost || !p1[0]) return;
`ifdef PTW_SUPERPAGE_EN
      if (p1[2]) begin
         exp_res = (p1 & 32'hFFC0_0FFF) | (32'(va[21:12]) * 32'd4096);
         return;
      end
`endif
      exp_n       = 2;
      exp_addr[1] = 32'(p1[31:12]) * 32'd4096 + 32'(va[21:12]) * 32'd4;
      p0          = rd(exp_addr[1]);
      exp_res     = p0[0] ? p0 : 32'h0;
   endtask

   // Memory: first request may stall, response after resp_dly cycles as a one-cycle pulse.
   initial begin
      mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_rdata_i = '0;
      forever begin
         @(negedge clk);
         mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_rdata_i = '0;
         if (pend) begin
            if (dly_left > 0) dly_left--;
            else begin
               mem_resp_valid_i = 1'b1; mem_rdata_i = rd(pend_addr); pend = 1'b0;
            end
         end else if (mem_req_valid_o && rst_n) begin
            if (stall_left > 0) stall_left--;
            else begin
               mem_req_ready_i = 1'b1;
               if (n_grants < 2) got_addr[n_grants] = mem_addr_o;
               n_grants++;
               pend = !no_resp; pend_addr = mem_addr_o; dly_left = resp_dly; stall_left = 0;
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      if (rst_n) begin
         chk("mon_req_ready", 32'(ptw_req_ready_o), 32'(!busy));
         if (!busy) begin
            chk("mon_idle_mem_req", 32'(mem_req_valid_o), 32'h0);
            chk("mon_idle_resp", 32'(ptw_resp_valid_o), 32'h0);
         end
         chk("mon_pte", ptw_pte_o, ptw_resp_valid_o ? exp_res : 32'h0);
         if (mem_req_valid_o) begin
            chk("mon_req_count", 32'(n_grants < exp_n), 32'h1);
            chk("mon_mem_addr", mem_addr_o, exp_addr[n_grants > 1 ? 1 : n_grants]);
         end
      end
   end

   task automatic walk(input string nm, input logic [19:0] pt, input logic [31:0] va,
                       input int stall, input int hold);
      int k;
      k = 0;
      while (pend && k < 100) begin @(negedge clk); k++; end
      model(pt, va);
      stall_left = stall; n_grants = 0; got_addr[0] = '0; got_addr[1] = '0;
      @(negedge clk);
      ptw_req_valid_i = 1'b1; ptbr_i = pt; ptw_vaddr_i = va;
      k = 0;
      while (!ptw_req_ready_o && k < 20) begin @(negedge clk); k++; end
      chk({nm, "_accept"}, 32'(ptw_req_ready_o), 32'h1);
      @(posedge clk); busy = 1'b1;
      @(negedge clk);
      ptw_req_valid_i = 1'b0; ptbr_i = ~pt; ptw_vaddr_i = ~va;
      lat = 0;
      do begin @(posedge clk); lat++; #1; end while (!ptw_resp_valid_o && lat < 200);
      chk({nm, "_resp_valid"}, 32'(ptw_resp_valid_o), 32'h1);
      got_pte = ptw_pte_o;
      repeat (hold) @(posedge clk);
      #1 chk({nm, "_resp_held"}, 32'(ptw_resp_valid_o), 32'h1);
      @(negedge clk); ptw_resp_ready_i = 1'b1;
      @(posedge clk); busy = 1'b0;
      @(negedge clk); ptw_resp_ready_i = 1'b0;
      chk({nm, "_pte_model"}, got_pte, exp_res);
      chk({nm, "_nreq_model"}, 32'(n_grants), 32'(exp_n));
   endtask

   initial begin : main
      logic [19:0] pt;
      logic [31:0] va, p1, a1;
      int k;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_req_ready", 32'(ptw_req_ready_o), 32'h0);
      chk("rst_resp_valid", 32'(ptw_resp_valid_o), 32'h0);
      chk("rst_pte", ptw_pte_o, 32'h0);
      chk("rst_mem_req", 32'(mem_req_valid_o), 32'h0);
      chk("rst_mem_resp_ready", 32'(mem_resp_ready_o), 32'h0);
      @(negedge clk); rst_n = 1'b1;
      #1 chk("rst_release_ready", 32'(ptw_req_ready_o), 32'h1);

      mem[32'h00080120] = 32'h00100001; mem[32'h00100D14] = 32'hABCDE003;
      walk("basic", 20'h00080, 32'h12345678, 0, 0);
      chk("basic_addr0", got_addr[0], 32'h00080120);
      chk("basic_addr1", got_addr[1], 32'h00100D14);
      chk("basic_pte", got_pte, 32'hABCDE003);
      chk("basic_latency", 32'(lat), 32'd4);

      mem[32'h00080120] = 32'h0;
      walk("l1_invalid", 20'h00080, 32'h12345678, 0, 0);
      chk("l1_invalid_nreq", 32'(n_grants), 32'd1);
      chk("l1_invalid_pte", got_pte, 32'h0);

      mem[32'h00080120] = 32'h40000005; mem[32'h40000D14] = 32'h7777700B;
      walk("super", 20'h00080, 32'h12345678, 0, 0);
`ifdef PTW_SUPERPAGE_EN
      chk("super_pte", got_pte, 32'h40345005);
      chk("super_nreq", 32'(n_grants), 32'd1);
`else
      chk("super_addr1", got_addr[1], 32'h40000D14);
      chk("super_pte", got_pte, 32'h7777700B);
`endif

      mem[32'h00080120] = 32'h00100001; mem[32'h00100D14] = 32'hABCDE002;
      walk("l0_invalid", 20'h00080, 32'h12345678, 0, 0);
      chk("l0_invalid_pte", got_pte, 32'h0);
      chk("l0_invalid_nreq", 32'(n_grants), 32'd2);

      mem[32'h00100D14] = 32'hABCDE003;
      no_resp = 1'b1;
      walk("timeout", 20'h00080, 32'h12345678, 0, 0);
      no_resp = 1'b0;
      chk("timeout_latency", 32'(lat), 32'd17);
      chk("timeout_pte", got_pte, 32'h0);

      resp_dly = T - 1;
      walk("expiry_edge", 20'h00080, 32'h12345678, 0, 0);
      chk("expiry_edge_pte", got_pte, 32'hABCDE003);
      chk("expiry_edge_latency", 32'(lat), 32'd34);
      resp_dly = T;
      walk("late_resp", 20'h00080, 32'h12345678, 0, 0);
      chk("late_resp_pte", got_pte, 32'h0);
      chk("late_resp_latency", 32'(lat), 32'd17);
      resp_dly = 0;

      walk("stall", 20'h00080, 32'h12345678, 3, 5);
      chk("stall_latency", 32'(lat), 32'd7);
      chk("stall_pte", got_pte, 32'hABCDE003);

      resp_dly = 3;
      model(20'h00080, 32'h12345678);
      n_grants = 0; stall_left = 0;
      @(negedge clk); ptw_req_valid_i = 1'b1; ptbr_i = 20'h00080; ptw_vaddr_i = 32'h12345678;
      @(posedge clk); busy = 1'b1;
      @(negedge clk); ptw_req_valid_i = 1'b0;
      k = 0;
      while (n_grants < 2 && k < 100) begin @(posedge clk); k++; end
      chk("midrst_reach_l0", 32'(n_grants), 32'd2);
      #2 rst_n = 1'b0; busy = 1'b0;
      #1;
      chk("midrst_resp_valid", 32'(ptw_resp_valid_o), 32'h0);
      chk("midrst_mem_resp_ready", 32'(mem_resp_ready_o), 32'h0);
      chk("midrst_req_ready", 32'(ptw_req_ready_o), 32'h0);
      @(negedge clk); @(negedge clk); rst_n = 1'b1;
      #1 chk("midrst_release_ready", 32'(ptw_req_ready_o), 32'h1);
      repeat (8) @(posedge clk);
      resp_dly = 0;
      walk("post_rst", 20'h00080, 32'h12345678, 0, 0);
      chk("post_rst_pte", got_pte, 32'hABCDE003);

      for (int i = 0; i < 4; i++) begin
         pt = 20'($urandom); va = $urandom;
         a1 = 32'(pt) * 32'd4096 + 32'(va[31:22]) * 32'd4;
         p1 = ($urandom & 32'hFFFF_F0FA) | 32'h1;
         mem[a1] = p1;
         mem[32'(p1[31:12]) * 32'd4096 + 32'(va[21:12]) * 32'd4] = $urandom;
         resp_dly = i;
         walk("rand", pt, va, i, i);
      end
      resp_dly = 0;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
